// File: rtl/lsu_ctrl.sv
// Load/store controller between the MEM stage and a word-only data memory; sub-word stores use read-modify-write.
// Define LSU_BIG_ENDIAN_EN for big-endian byte/halfword lane mapping (little-endian otherwise).
module lsu_ctrl #(
    parameter int DMEM_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        req_err,
    output logic        dm_we,
    output logic [31:0] dm_adr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        RMW_WRITE = 2'b10
    } state_t;

    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    localparam logic [30:0] WORDS_L = 31'(DMEM_WORDS);

    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] boff;
`ifdef LSU_BIG_ENDIAN_EN
        boff = ~off;
`else
        boff = off;
`endif
        case (size)
            SZ_BYTE: return {boff, 3'b000};
            SZ_HALF: return {boff[1], 4'b0000};
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [4:0] shift);
        logic [31:0] s;
        s = word >> shift;
        case (size)
            SZ_BYTE: return {{24{~uns & s[7]}}, s[7:0]};
            SZ_HALF: return {{16{~uns & s[15]}}, s[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [1:0] size, input logic [4:0] shift);
        logic [31:0] mask;
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF;
            SZ_HALF: mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (old_w & ~(mask << shift)) | ((new_w & mask) << shift);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        err_q, err_d;

    logic        accept_s;
    logic        bad_s;
    logic        dm_we_s;
    logic [31:0] dm_adr_s;
    logic [31:0] dm_wdata_s;
    logic [4:0]  shift_s;

    assign req_ready = (state_q == IDLE) & ~RST;
    assign accept_s  = req_valid & req_ready;
    assign shift_s   = lane_shift(size_q, addr_q[1:0]);

    assign bad_s = (req_size == 2'b11)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                 | ({1'b0, req_addr[31:2]} >= WORDS_L);

    // Next-state, held-request capture and memory-side drive
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        err_d        = 1'b0;
        dm_we_s      = 1'b0;
        dm_adr_s     = {addr_q[31:2], 2'b00};
        dm_wdata_s   = wdata_q;
        case (state_q)
            IDLE: begin
                dm_adr_s   = {req_addr[31:2], 2'b00};
                dm_wdata_s = req_wdata;
                if (accept_s) begin
                    if (bad_s) begin
                        err_d = 1'b1;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        dm_we_s = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        wdata_d = req_wdata;
                        state_d = req_we ? RMW_WRITE : LOAD_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_WAIT: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = lane_extract(dm_rdata, size_q, uns_q, shift_s);
                state_d      = IDLE;
            end
            RMW_WRITE: begin
                dm_we_s    = 1'b1;
                dm_wdata_s = lane_merge(dm_rdata, wdata_q, size_q, shift_s);
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A reset arriving mid-RMW must suppress the pending write at once
    assign dm_we      = dm_we_s & ~RST;
    assign dm_adr     = dm_adr_s;
    assign dm_wdata   = dm_wdata_s;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign req_err    = err_q;

    // State, held request and registered response
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            addr_q       <= 32'h0000_0000;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            wdata_q      <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed steps plus random accesses against a byte-array reference model.
module tb_lsu_ctrl;
    localparam int W = 256;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, req_err, dm_we;
    logic [31:0] resp_rdata, dm_adr, dm_wdata, dm_rdata;

    logic [31:0] mem [0:W-1];
    logic [7:0]  rb  [0:4*W-1];
    int total = 0;
    int bad = 0;

    lsu_ctrl #(.DMEM_WORDS(W)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .req_err(req_err), .dm_we(dm_we), .dm_adr(dm_adr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    always #5 CLK = ~CLK;

    // Word memory: synchronous write, read data valid the cycle after the address
    always @(posedge CLK) begin
        if (dm_we && (dm_adr[31:2] < W)) mem[dm_adr[31:2]] <= dm_wdata;
        dm_rdata <= (dm_adr[31:2] < W) ? mem[dm_adr[31:2]] : 32'h0000_0000;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
`ifdef LSU_BIG_ENDIAN_EN
        return {rb[4*idx], rb[4*idx+1], rb[4*idx+2], rb[4*idx+3]};
`else
        return {rb[4*idx+3], rb[4*idx+2], rb[4*idx+1], rb[4*idx]};
`endif
    endfunction

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
            || (a[31:2] >= W);
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 1 << sz;
        for (int k = 0; k < n; k++) begin
`ifdef LSU_BIG_ENDIAN_EN
            rb[int'(a) + k] = 8'(wd >> (8 * (n - 1 - k)));
`else
            rb[int'(a) + k] = 8'(wd >> (8 * k));
`endif
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = 32'h0000_0000;
        for (int k = 0; k < n; k++) begin
`ifdef LSU_BIG_ENDIAN_EN
            v = v | (32'(rb[int'(a) + k]) << (8 * (n - 1 - k)));
`else
            v = v | (32'(rb[int'(a) + k]) << (8 * k));
`endif
        end
        if (sz == 2'b00 && !uns && v[7]) v = v | 32'hFFFF_FF00;
        else if (sz == 2'b01 && !uns && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // One request; starts and ends just after a rising edge
    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] seen);
        logic err;
        err = ref_err(sz, a);
        seen = 32'h0000_0000;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(negedge CLK);
        chk("ready_T", req_ready, 32'd1);
        chk("adr_T", dm_adr, {a[31:2], 2'b00});
        chk("we_T", dm_we, {31'd0, (!err && we && sz == 2'b10)});
        chk("rv_T", resp_valid, 32'd0);
        chk("err_T", req_err, 32'd0);
        if (!err && we && sz == 2'b10) begin
            chk("wdata_T", dm_wdata, wd);
            seen = dm_wdata;
        end
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(negedge CLK);
        chk("err_T1", req_err, {31'd0, err});
        chk("rv_T1", resp_valid, 32'd0);
        if (err) begin
            chk("we_T1", dm_we, 32'd0);
            chk("ready_T1", req_ready, 32'd1);
        end else if (we && sz == 2'b10) begin
            ref_store(sz, a, wd);
            chk("ready_T1", req_ready, 32'd1);
            chk("we_T1", dm_we, 32'd0);
        end else if (we) begin
            ref_store(sz, a, wd);
            chk("ready_T1", req_ready, 32'd0);
            chk("we_T1", dm_we, 32'd1);
            chk("adr_T1", dm_adr, {a[31:2], 2'b00});
            chk("rmw_wdata", dm_wdata, ref_word(int'(a[31:2])));
            seen = dm_wdata;
        end else begin
            chk("ready_T1", req_ready, 32'd0);
            chk("we_T1", dm_we, 32'd0);
            @(negedge CLK);
            chk("rv_T2", resp_valid, 32'd1);
            chk("err_T2", req_err, 32'd0);
            chk("rdata", resp_rdata, ref_load(sz, uns, a));
            chk("ready_T2", req_ready, 32'd1);
            seen = resp_rdata;
        end
        @(posedge CLK); #1;
        if (we && !err) chk("mem", mem[a[31:2]], ref_word(int'(a[31:2])));
    endtask

    initial begin
        logic [31:0] s;
        logic [1:0]  sz;
        logic [31:0] a;
        int r;
        RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0000_0000; req_wdata = 32'h0000_0000;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", req_ready, 32'd0);
        chk("rst_rv", resp_valid, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", req_err, 32'd0);
        chk("rst_we", dm_we, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 16; i++) access(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, s);

`ifndef LSU_BIG_ENDIAN_EN
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, s); chk("sw_wd", s, 32'hDEAD_BEEF);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, s);         chk("lw", s, 32'hDEAD_BEEF);
        access(1'b1, 2'b00, 1'b0, 32'h11, 32'hAA, s);        chk("sb_wd", s, 32'hDEAD_AAEF);
        access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, s);         chk("lb", s, 32'hFFFF_FFAA);
        access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, s);         chk("lbu", s, 32'h0000_00AA);
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, s);
        access(1'b1, 2'b01, 1'b0, 32'h12, 32'h8001, s);      chk("sh_wd", s, 32'h8001_0000);
        access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, s);         chk("lh", s, 32'hFFFF_8001);
        access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, s);         chk("lhu", s, 32'h0000_8001);
`else
        access(1'b1, 2'b10, 1'b0, 32'h0, 32'h1122_3344, s);
        access(1'b0, 2'b00, 1'b1, 32'h0, 32'h0, s);          chk("be_lbu", s, 32'h0000_0011);
        access(1'b1, 2'b00, 1'b0, 32'h3, 32'hFF, s);         chk("be_sb_wd", s, 32'h1122_33FF);
        access(1'b0, 2'b01, 1'b0, 32'h0, 32'h0, s);          chk("be_lh", s, 32'h0000_1122);
`endif

        access(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, s);
        access(1'b1, 2'b10, 1'b0, 32'h16, 32'h1234_5678, s);
        access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, s);
        access(1'b0, 2'b10, 1'b0, 32'(W * 4), 32'h0, s);
        access(1'b1, 2'b00, 1'b0, 32'(W * 4 + 1), 32'h55, s);

        // Reset in the middle of a read-modify-write
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h15; req_wdata = 32'h0000_0077;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        chk("rmw_we_pre", dm_we, 32'd1);
        RST = 1'b1;
        #1;
        chk("rmw_rst_we", dm_we, 32'd0);
        chk("rmw_rst_ready", req_ready, 32'd0);
        @(posedge CLK); #1;
        chk("rmw_rst_mem", mem[5], ref_word(5));
        chk("rmw_rst_ready2", req_ready, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("rmw_rel_ready", req_ready, 32'd1);
        access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, s);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            if ($urandom_range(0, 11) == 0) a = 32'(W * 4) + 32'($urandom_range(0, 255));
            else a = 32'($urandom_range(0, 63));
            access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit between the MIPS MEM pipeline stage and the word-only data memory DM.
- Handles lb/lbu/lh/lhu/lw and sb/sh/sw.
- Byte and halfword stores use a two-cycle read-modify-write, because DM writes whole words only.
- Sign/zero-extends load data, checks alignment and range, and stalls the pipeline while busy.

Parameters:
- DMEM_WORDS, 1024: DM depth in 32-bit words; must equal DM's DMEM_SIZE. Word index = addr[31:2] >= DMEM_WORDS is out of range.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-high reset
- req_valid  in  1  access request from MEM stage
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- resp_valid  out  1  one-cycle pulse, load data valid
- resp_rdata  out  32  extended load data
- req_err  out  1  one-cycle pulse, misaligned/illegal/out-of-range access
- dm_we  out  1  to DM WE
- dm_adr  out  32  to DM Adr, always {addr[31:2],2'b00}
- dm_wdata  out  32  to DM WDATA
- dm_rdata  in  32  from DM Rdata; valid the cycle after a read address is presented

Behaviour:
- Reset (async): state=IDLE; resp_valid=0, resp_rdata=0, req_err=0.
  - dm_we forced 0 while RST is high, including mid-RMW; an interrupted RMW writes nothing.
  - req_ready=0 while RST is high.
- States: IDLE, LOAD_WAIT, RMW_WRITE.
- dm_we, dm_adr and dm_wdata are combinational from state and the held request.
- req_ready=1 only in IDLE.
- Error check (IDLE, on accept):
  - half with addr[0]=1, word with addr[1:0]!=0, size 11, or out-of-range index.
  - Result: dm_we=0, no state change, req_err=1 on the next cycle, no resp_valid.
- IDLE, store word accepted (cycle T): dm_we=1, dm_wdata=req_wdata in T; remain IDLE; no stall.
- IDLE, load accepted at T:
  - dm_adr driven in T; latch size, unsigned and addr[1:0]; go to LOAD_WAIT.
  - In LOAD_WAIT (T+1), select the lane from dm_rdata and extend.
  - Register resp_rdata; resp_valid=1 in T+2; return to IDLE at T+2.
  - A new request may be accepted at T+2.
- IDLE, sub-word store accepted at T:
  - dm_we=0, dm_adr driven; latch addr, size and wdata; go to RMW_WRITE.
  - In RMW_WRITE (T+1): dm_we=1, dm_wdata = dm_rdata with the target lane replaced by wdata[7:0] or wdata[15:0]; return to IDLE.
- Lane mapping (little-endian):
  - byte = bits [8*addr[1:0]+7 : 8*addr[1:0]]
  - half = bits [16*addr[1]+15 : 16*addr[1]]
- Extension:
  - signed: replicate bit 7 or bit 15.
  - unsigned: zero-fill.
- Back-to-back: a load immediately after a store to the same word returns the new data. DM's write completes before the next read, so no forwarding is needed.
- resp_valid, req_err: exactly one cycle each; never both high in the same cycle.

Optional Feature:
- LSU_BIG_ENDIAN_EN defined: big-endian lanes.
  - byte lane = bits [31-8*addr[1:0] -: 8]
  - half at addr[1]=0 is bits [31:16]
  - Applies to both load extraction and RMW merge.
- Undefined: little-endian mapping as above.

Test Plan:
- Reset, then sw 0xDEADBEEF @0x10 (dm_we=1 same cycle), then lw @0x10: resp_valid at T+2, resp_rdata=0xDEADBEEF, req_ready low only at T+1.
- sb 0xAA @0x11 onto 0xDEADBEEF: dm_we low at T, high at T+1 with dm_wdata=0xDEADAAEF; then lb @0x11 returns 0xFFFFFFAA and lbu returns 0x000000AA.
- sh 0x8001 @0x12 onto 0x00000000: dm_wdata=0x80010000; lh @0x12 returns 0xFFFF8001, lhu returns 0x00008001.
- lh @0x13, sw @0x16, size=11, and lw @(DMEM_WORDS*4): each gives req_err pulse at T+1, dm_we never high, no resp_valid.
- Assert RST during RMW_WRITE: dm_we drops immediately, DM word unchanged, req_ready low while RST high, state IDLE after release.
- With LSU_BIG_ENDIAN_EN, word 0x11223344: lbu @0x0 returns 0x11; sb 0xFF @0x3 gives dm_wdata=0x112233FF.
